// File: rtl/interp_pkg.sv
// ============================================================================
// Module : interp_pkg
// Brief  : Shared types and width helpers for multichannel_interp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package interp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // One guard bit above |diff| * frac so the shift-add never wraps.
    function automatic int acc_width(input int data_width, input int frac_bits);
        return data_width + frac_bits + 1;
    endfunction

    function automatic int round_const(input int frac_bits);
        return 1 << (frac_bits - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/interp_sign_mag.sv
// ============================================================================
// Module : interp_sign_mag
// Brief  : Signed value -> (sign, magnitude) split plus the inverse recombine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module interp_sign_mag #(
    parameter int W = 17
) (
    input  logic [W-1:0] i_value,
    output logic         o_sign,
    output logic [W-1:0] o_mag,
    input  logic         i_sign,
    input  logic [W-1:0] i_mag,
    output logic [W-1:0] o_value
);

    // Inputs are bounded so the magnitude never needs more than W bits.
    assign o_sign  = i_value[W-1];
    assign o_mag   = i_value[W-1] ? (~i_value + 1'b1) : i_value;
    assign o_value = i_sign ? (~i_mag + 1'b1) : i_mag;

endmodule

`default_nettype wire

// File: rtl/multichannel_interp.sv
// ============================================================================
// Module : multichannel_interp
// Brief  : Handshaked shift-add linear interpolator with channel pass-through.
//          Define INTERP_ROUND_EN for round-half-away-from-zero results.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multichannel_interp
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 4,
    parameter int CHANNELS   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [ch_width(CHANNELS)-1:0] i_in_channel,
    input  logic [DATA_WIDTH-1:0]         i_base,
    input  logic [DATA_WIDTH-1:0]         i_target,
    input  logic [FRAC_BITS-1:0]          i_frac,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [ch_width(CHANNELS)-1:0] o_out_channel,
    output logic [DATA_WIDTH-1:0]         o_out_data
);

    localparam int CH_W  = ch_width(CHANNELS);
    localparam int ACC_W = acc_width(DATA_WIDTH, FRAC_BITS);
    localparam int MAG_W = DATA_WIDTH + 1;
    localparam int CNT_W = $clog2(FRAC_BITS + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_last;

    logic [DATA_WIDTH-1:0] r_base;
    logic [CH_W-1:0]       r_channel;
    logic [FRAC_BITS-1:0]  r_frac;
    logic                  r_neg;
    logic [MAG_W-1:0]      r_mag;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]       r_out_channel;

    logic [MAG_W-1:0]      w_diff;
    logic                  w_diff_sign;
    logic [MAG_W-1:0]      w_diff_mag;
    logic [ACC_W-1:0]      w_acc_next;
    logic [ACC_W-1:0]      w_acc_fin;
    logic [MAG_W-1:0]      w_step_mag;
    logic [MAG_W-1:0]      w_step_val;
    logic [MAG_W-1:0]      w_base_ext;

    // Widened by one bit so target - base cannot overflow.
    assign w_diff = {i_target[DATA_WIDTH-1], i_target} - {i_base[DATA_WIDTH-1], i_base};

    interp_sign_mag #(
        .W (MAG_W)
    ) u_sign_mag (
        .i_value (w_diff),
        .o_sign  (w_diff_sign),
        .o_mag   (w_diff_mag),
        .i_sign  (r_neg),
        .i_mag   (w_step_mag),
        .o_value (w_step_val)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_in_ready  = 1'b1;
                    w_state_nxt = i_in_valid ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (reset) begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept      = i_in_valid & w_in_ready;
    assign w_last        = (r_cnt == '0);
    assign o_in_ready    = w_in_ready;
    assign o_out_valid   = w_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_channel = r_out_channel;

    // ------------------------------------------------------------ datapath
    // frac is shifted left each iteration so its MSB is always the live bit.
    assign w_acc_next = {r_acc[ACC_W-2:0], 1'b0}
                      + (r_frac[FRAC_BITS-1] ? ACC_W'(r_mag) : '0);

`ifdef INTERP_ROUND_EN
    localparam logic [ACC_W-1:0] c_RND = ACC_W'(round_const(FRAC_BITS));
    assign w_acc_fin = w_acc_next + c_RND;
`else
    assign w_acc_fin = w_acc_next;
`endif

    assign w_step_mag = MAG_W'(w_acc_fin >> FRAC_BITS);
    assign w_base_ext = {r_base[DATA_WIDTH-1], r_base};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base        <= '0;
            r_channel     <= '0;
            r_frac        <= '0;
            r_neg         <= 1'b0;
            r_mag         <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_out_data    <= '0;
            r_out_channel <= '0;
        end else if (w_accept) begin
            r_base    <= i_base;
            r_channel <= i_in_channel;
            r_frac    <= i_frac;
            r_neg     <= w_diff_sign;
            r_mag     <= w_diff_mag;
            r_acc     <= '0;
            r_cnt     <= CNT_W'(FRAC_BITS - 1);
        end else if (r_state == ST_RUN) begin
            r_acc  <= w_acc_next;
            r_frac <= r_frac << 1;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) begin
                // Result is bounded by base and target, so truncation is lossless.
                r_out_data    <= DATA_WIDTH'(w_base_ext + w_step_val);
                r_out_channel <= r_channel;
            end
        end
    end

endmodule

`default_nettype wire
